// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative FP divide/sqrt sequencer.
package fpu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int DIV_CYCLES_DEF  = 13;
  localparam int SQRT_CYCLES_DEF = 17;
  localparam int CNT_W_DEF       = 5;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;
endpackage

// File: rtl/fdivsqrt_sched_if.sv
// ID-side request fields and writeback handshake of the divide/sqrt sequencer.
interface fdivsqrt_sched_if #(parameter int CNT_W = 5);
  logic             i_fdiv, i_fsqrt;
  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2, id_fwr;
  logic [1:0]       rm;
  logic             start_div, start_sqrt;
  logic [1:0]       op_rm;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             stall;
  logic             wb_req, wb_gnt;
  logic [4:0]       wb_rd;
  logic             wb_is_sqrt;

  modport master (
    output i_fdiv, i_fsqrt, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fwr, rm, wb_gnt,
    input  start_div, start_sqrt, op_rm, busy, count, stall, wb_req, wb_rd, wb_is_sqrt
  );
  modport slave (
    input  i_fdiv, i_fsqrt, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fwr, rm, wb_gnt,
    output start_div, start_sqrt, op_rm, busy, count, stall, wb_req, wb_rd, wb_is_sqrt
  );
endinterface

// File: rtl/fpu_hazard_cmp.sv
// RAW/WAW compare of the ID register fields against the in-flight destination.
module fpu_hazard_cmp (
  input  logic       busy,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       fwr,
  input  logic [4:0] wb_rd,
  output logic       hazard
);
  // f0 is an ordinary FP register, so no zero-register exemption here.
  assign hazard = busy & ((use_rs1 & (id_rs1 == wb_rd)) |
                          (use_rs2 & (id_rs2 == wb_rd)) |
                          (fwr     & (id_rd  == wb_rd)));
endmodule

// File: rtl/fdivsqrt_sched.sv
// Issues one fdiv/fsqrt at a time, counts its fixed latency, stalls ID on
// hazards and holds the result until the shared FP writeback port is granted.
module fdivsqrt_sched
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int SQRT_CYCLES = SQRT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic clrn,
  input  logic ena,
  fdivsqrt_sched_if.slave b
);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQRT_LD = CNT_W'(SQRT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       rd_q;
  logic [1:0]       rm_q;
  logic             sqrt_q;
  logic             req, issue, hazard;

  // fdiv wins when both request bits are up.
  assign req   = b.i_fdiv | b.i_fsqrt;
  assign issue = ena & (state == IDLE) & req;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (ena) begin
      case (state)
        IDLE: if (req) begin
          state_n = RUN;
          cnt_n   = b.i_fdiv ? DIV_LD : SQRT_LD;
        end
        RUN: if (cnt == '0) state_n = WB;
             else           cnt_n   = cnt - 1'b1;
        WB:   if (b.wb_gnt) state_n = IDLE;
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_q   <= '0;
      rm_q   <= '0;
      sqrt_q <= 1'b0;
    end else if (issue) begin
      rd_q   <= b.id_rd;
      rm_q   <= b.rm;
      sqrt_q <= ~b.i_fdiv;
    end
  end

  fpu_hazard_cmp u_hz (
    .busy    (b.busy),
    .id_rd   (b.id_rd),
    .id_rs1  (b.id_rs1),
    .id_rs2  (b.id_rs2),
    .use_rs1 (b.id_use_rs1),
    .use_rs2 (b.id_use_rs2),
    .fwr     (b.id_fwr),
    .wb_rd   (rd_q),
    .hazard  (hazard)
  );

  assign b.start_div  = issue & b.i_fdiv;
  assign b.start_sqrt = issue & ~b.i_fdiv;
  assign b.busy       = (state != IDLE);
  assign b.wb_req     = (state == WB);
  assign b.count      = (state == RUN) ? cnt : '0;
  assign b.stall      = (b.busy & req) | hazard;
  assign b.wb_rd      = rd_q;
  assign b.wb_is_sqrt = sqrt_q;
  assign b.op_rm      = rm_q;
endmodule

// File: doc/fdivsqrt_sched.md
Name: fdivsqrt_sched

Overview:
Issue/sequencing controller for the shared iterative floating-point unit (Newton divider plus Newton square-root). It sits between the ID stage and the unit. It accepts one fdiv or fsqrt at a time, pulses the matching start, and counts the fixed iteration latency. It stalls ID on structural and register hazards, then arbitrates for the shared FP writeback port. ena freezes the block together with the rest of the pipeline.

Parameters:
DIV_CYCLES, 13, cycles from start to divider result valid (≥2)
SQRT_CYCLES, 17, cycles from start to sqrt result valid (≥2)
CNT_W, 5, counter width; must hold max(DIV_CYCLES,SQRT_CYCLES)-1

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
ena  in  1  pipeline enable; 0 freezes all state
i_fdiv  in  1  ID holds fdiv
i_fsqrt  in  1  ID holds fsqrt
id_rd  in  5  destination FP register of ID instruction
id_rs1  in  5  FP source 1 of ID instruction
id_rs2  in  5  FP source 2 of ID instruction
id_use_rs1  in  1  ID reads rs1 from FP file
id_use_rs2  in  1  ID reads rs2 from FP file
id_fwr  in  1  ID instruction writes FP file (id_rd)
rm  in  2  rounding mode of ID instruction
start_div  out  1  one-cycle start to divider
start_sqrt  out  1  one-cycle start to sqrt
op_rm  out  2  latched rounding mode of in-flight op
busy  out  1  an op is in flight (RUN or WB)
count  out  CNT_W  remaining cycles in RUN, else 0
stall  out  1  ID stage stall
wb_req  out  1  result ready, requesting writeback port
wb_gnt  in  1  writeback port granted this cycle
wb_rd  out  5  destination of in-flight op
wb_is_sqrt  out  1  result mux select: 1 sqrt, 0 div

Behaviour:
- Reset (clrn=0, async): state IDLE. All outputs and registers 0. An in-flight op is abandoned and no writeback occurs.
- ena=0: state, counter and latches hold. start_*=0, wb_req holds its value, and stall is computed normally.
- States: IDLE, RUN, WB.
- Request: req = i_fdiv | i_fsqrt. If both are high, fdiv wins and fsqrt is ignored.
- IDLE, ena=1, req=1: latch id_rd, rm, and op (is_sqrt). Assert the start_div or start_sqrt pulse combinationally in the same cycle. Load count = CYCLES-1 and go to RUN. stall=0 for this instruction.
- RUN, ena=1: count decrements. When count==0, go to WB next edge. Count stays at 0 in WB.
- WB: wb_req=1 and wb_rd/wb_is_sqrt are stable.
  - wb_gnt=1 with ena=1: go to IDLE next edge.
  - wb_gnt=0: hold WB indefinitely.
  - wb_gnt while not in WB is ignored.
- New ops are issued only from IDLE. The op held back in WB's grant cycle issues in the following IDLE cycle, giving a minimum spacing of CYCLES+2.
- stall=1 when busy and any of:
  - req=1 (structural hazard)
  - id_use_rs1 and id_rs1==wb_rd (RAW)
  - id_use_rs2 and id_rs2==wb_rd (RAW)
  - id_fwr and id_rd==wb_rd (WAW)
- No hazard checks are made for register 0; FP f0 is an ordinary register.
- The latency seen by ID is start cycle + CYCLES + 1 (WB) + grant wait.

Decomposition:
- Shared package fpu_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, WB=2'd2)
  - DIV_CYCLES and SQRT_CYCLES defaults
  - rounding-mode constants
- One sub-module, fpu_hazard_cmp, handles the combinational RAW/WAW compare of the ID fields against wb_rd, qualified by busy.
- The counter and FSM stay in the top module.

Test Plan:
- Basic fdiv: i_fdiv=1, rd=5, rm=2 in IDLE.
  - Required: start_div pulse one cycle, busy=1, count 12→0 over 13 cycles.
  - Then wb_req=1 with wb_rd=5, wb_is_sqrt=0, op_rm=2.
  - wb_gnt=1 → IDLE next cycle.
- Structural stall: fsqrt issue, then i_fdiv held.
  - Required: stall=1 throughout RUN and WB.
  - fdiv start_div asserts in the first IDLE cycle after grant.
- Hazards with fdiv to rd=7 in flight:
  - ID reads rs2=7 with use_rs2=1 → stall=1.
  - rs2=7 with use_rs2=0 → stall=0.
  - id_fwr=1 with id_rd=7 → stall=1.
- Grant backpressure: hold wb_gnt=0 for 5 cycles in WB.
  - Required: wb_req and wb_rd stable, stall persists.
  - Grant on cycle 6 → IDLE.
- Freeze and reset:
  - ena=0 for 3 cycles mid-RUN at count=8 → count holds 8, then resumes at 7.
  - clrn=0 mid-RUN → busy, count, wb_req and stall all 0 immediately, and no wb_req ever appears.
- Both i_fdiv and i_fsqrt high in IDLE → only start_div pulses and wb_is_sqrt=0.
